// File: rtl/adder_stim_pkg.sv
// adder_stim shared types and constants.
// State enum, datapath widths and the LFSR feedback polynomial.
package adder_stim_pkg;

  localparam int OPW   = 16;
  localparam int SUMW  = 17;
  localparam int CNTW  = 16;
  localparam int LFSRW = 32;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [LFSRW-1:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/adder_stim_lfsr.sv
// 32-bit Galois LFSR with synchronous load and step enable.
// Ports: clk, rst_n (async low, resets to SEED), load, en, o_state.
module adder_stim_lfsr
  import adder_stim_pkg::*;
#(
  parameter logic [LFSRW-1:0] SEED = 32'hACE1_2013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [LFSRW-1:0] o_state
);

  logic [LFSRW-1:0] lfsr_q;
  logic [LFSRW-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (en) begin
      lfsr_d = {1'b0, lfsr_q[LFSRW-1:1]}
             ^ (lfsr_q[0] ? LFSR_POLY : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_state = lfsr_q;

endmodule

// File: rtl/adder_stim.sv
// Adder self-test stimulus generator and checker.
// Ports: clk, rst_n, i_start, o_a/o_b out, i_sum in, o_busy, o_done, o_pass, o_err_count, o_vec_count.
module adder_stim
  import adder_stim_pkg::*;
#(
  parameter int               LATENCY     = 1,
  parameter int               NUM_VECTORS = 256,
  parameter logic [LFSRW-1:0] SEED        = 32'hACE1_2013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  output logic [OPW-1:0]  o_a,
  output logic [OPW-1:0]  o_b,
  input  logic [SUMW-1:0] i_sum,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [CNTW-1:0] o_err_count,
  output logic [CNTW-1:0] o_vec_count
);

  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NUM_VECTORS - 1);
  localparam logic [CNTW-1:0] NV       = CNTW'(NUM_VECTORS);

  // Release of reset is re-timed; assertion stays asynchronous.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_int_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  state_e           state_q, state_d;
  logic [OPW-1:0]   a_q, a_d;
  logic [OPW-1:0]   b_q, b_d;
  logic [CNTW-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNTW-1:0]  vec_q, vec_d;
  logic [CNTW-1:0]  err_q, err_d;
  logic [LFSRW-1:0] lfsr_state;
  logic             issue;
  logic             start_go;
  logic [SUMW-1:0]  exp_now;
  logic [SUMW-1:0]  exp_dly;
  logic             cmp_vld;
  logic             mismatch;

  assign issue    = (state_q == S_RUN);
  assign start_go = i_start
                  && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Operands come straight from the LFSR while issuing,
  // otherwise the last issued pair is held.
  assign o_a = issue ? lfsr_state[31:16] : a_q;
  assign o_b = issue ? lfsr_state[15:0]  : b_q;
  assign a_d = o_a;
  assign b_d = o_b;

  assign exp_now = {1'b0, o_a} + {1'b0, o_b};

  adder_stim_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_int_n),
    .load    (start_go),
    .en      (issue),
    .o_state (lfsr_state)
  );

  if (LATENCY == 0) begin : g_nodly
    assign exp_dly = exp_now;
    assign cmp_vld = issue;
  end else begin : g_dly
    logic [LATENCY-1:0]           vld_q, vld_d;
    logic [LATENCY-1:0][SUMW-1:0] exp_q, exp_d;

    always_comb begin
      vld_d[0] = issue;
      exp_d[0] = exp_now;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        exp_d[i] = exp_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
        vld_q <= '0;
        exp_q <= '0;
      end else begin
        vld_q <= vld_d;
        exp_q <= exp_d;
      end
    end

    assign exp_dly = exp_q[LATENCY-1];
    assign cmp_vld = vld_q[LATENCY-1];
  end

  assign mismatch = cmp_vld && (i_sum != exp_dly);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (i_start) state_d = S_RUN;
      S_RUN:   if (issue_cnt_q == LAST_IDX) state_d = S_DRAIN;
      S_DRAIN: if (vec_q == NV) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vec_d       = vec_q;
    err_d       = err_q;
    issue_cnt_d = issue_cnt_q;
    if (start_go) begin
      vec_d       = '0;
      err_d       = '0;
      issue_cnt_d = '0;
    end else begin
      if (issue) issue_cnt_d = issue_cnt_q + 1'b1;
      if (cmp_vld) begin
        vec_d = vec_q + 1'b1;
        if (mismatch && (err_q != '1)) err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      issue_cnt_q <= '0;
      vec_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      issue_cnt_q <= issue_cnt_d;
      vec_q       <= vec_d;
      err_q       <= err_d;
    end
  end

  assign o_busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign o_done      = (state_q == S_DONE);
  assign o_pass      = (state_q == S_DONE) && (err_q == '0);
  assign o_err_count = err_q;
  assign o_vec_count = vec_q;

endmodule

// File: tb/tb_adder_stim.sv
// Self-checking bench for adder_stim.
// Three instances: comb loopback, registered adder, stuck adder.
module tb_adder_stim;

  localparam logic [31:0] SEED = 32'hACE1_2013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, start0, busy0, done0, pass0;
  logic [15:0] a0, b0, err0, vec0;
  logic [16:0] sum0;

  logic        rst1, start1, busy1, done1, pass1, mode1;
  logic [15:0] a1, b1, err1, vec1;
  logic [16:0] sum1;

  logic        rst2, start2, busy2, done2, pass2;
  logic [15:0] a2, b2, err2, vec2;
  logic [16:0] sum2;

  assign sum0 = {1'b0, a0} + {1'b0, b0};

  // registered adder, optionally dropping the carry out
  always @(posedge clk) begin
    if (mode1) sum1 <= ({1'b0, a1} + {1'b0, b1}) & 17'h0FFFF;
    else       sum1 <= {1'b0, a1} + {1'b0, b1};
  end

  assign sum2 = 17'h1FFFF;

  adder_stim #(.LATENCY(0), .NUM_VECTORS(4), .SEED(SEED)) u_dut0 (
    .clk(clk), .rst_n(rst0), .i_start(start0),
    .o_a(a0), .o_b(b0), .i_sum(sum0),
    .o_busy(busy0), .o_done(done0), .o_pass(pass0),
    .o_err_count(err0), .o_vec_count(vec0)
  );

  adder_stim #(.LATENCY(1), .NUM_VECTORS(256), .SEED(SEED)) u_dut1 (
    .clk(clk), .rst_n(rst1), .i_start(start1),
    .o_a(a1), .o_b(b1), .i_sum(sum1),
    .o_busy(busy1), .o_done(done1), .o_pass(pass1),
    .o_err_count(err1), .o_vec_count(vec1)
  );

  adder_stim #(.LATENCY(8), .NUM_VECTORS(65535), .SEED(SEED)) u_dut2 (
    .clk(clk), .rst_n(rst2), .i_start(start2),
    .o_a(a2), .o_b(b2), .i_sum(sum2),
    .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_err_count(err2), .o_vec_count(vec2)
  );

  typedef struct packed {
    logic [15:0] vec;
    logic [15:0] err;
    logic        pass;
  } res_t;

  res_t sbq[$];
  res_t sb2[$];

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  // mode 0: correct adder, 1: carry dropped, 2: stuck at all ones
  function automatic res_t model_run(input int n, input int mode);
    logic [31:0] s;
    logic [16:0] full;
    int          e;
    res_t        r;
    s = SEED;
    e = 0;
    for (int i = 0; i < n; i++) begin
      full = {1'b0, s[31:16]} + {1'b0, s[15:0]};
      if (mode == 1 && full >= 17'h10000) e++;
      if (mode == 2 && full != 17'h1FFFF) e++;
      s = lfsr_step(s);
    end
    r.vec  = 16'(n);
    r.err  = (e > 65535) ? 16'hFFFF : 16'(e);
    r.pass = (e == 0);
    return r;
  endfunction

  task automatic pulse1();
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
  endtask

  task automatic finish_run1(input string tag, input int budget);
    int   c;
    res_t e;
    c = 0;
    while (!done1 && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk({tag, "_done"}, 32'(done1), 32'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, "_vec"},  32'(vec1),  32'(e.vec));
      chk({tag, "_err"},  32'(err1),  32'(e.err));
      chk({tag, "_pass"}, 32'(pass1), 32'(e.pass));
    end
  endtask

  initial begin
    int   cyc;
    res_t e;
    res_t drop_exp;

    rst0 = 0; rst1 = 0; rst2 = 0;
    start0 = 0; start1 = 0; start2 = 0;
    mode1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a",    32'(a1),    32'd0);
    chk("rst_b",    32'(b1),    32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_pass", 32'(pass1), 32'd0);
    chk("rst_err",  32'(err1),  32'd0);
    chk("rst_vec",  32'(vec1),  32'd0);
    chk("rst_a0",   32'(a0),    32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_a2",   32'({a2, b2}), 32'd0);

    // start asserted right at reset release
    @(negedge clk);
    rst0 = 1; rst1 = 1; rst2 = 1;
    start1 = 1;
    @(posedge clk);
    #1;
    chk("sync_edge1", 32'(busy1), 32'd0);
    cyc = 0;
    while (!busy1 && cyc < 4) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("sync_start", 32'(busy1), 32'd1);
    start1 = 0;
    sbq.push_back(model_run(256, 0));
    finish_run1("first", 400);

    // long saturating run runs alongside the rest
    @(negedge clk);
    start2 = 1;
    @(posedge clk);
    #1;
    start2 = 0;
    chk("l8_busy", 32'(busy2), 32'd1);
    sb2.push_back(model_run(65535, 2));

    // combinational loopback, zero latency
    @(negedge clk);
    start0 = 1;
    @(posedge clk);
    #1;
    start0 = 0;
    cyc = 0;
    while (!done0 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("l0_cycles", 32'(cyc),   32'd5);
    chk("l0_vec",    32'(vec0),  32'd4);
    chk("l0_err",    32'(err0),  32'd0);
    chk("l0_pass",   32'(pass0), 32'd1);

    // first vector and its one-cycle-late check
    pulse1();
    chk("v1_a",   32'(a1),   32'h0000ACE1);
    chk("v1_b",   32'(b1),   32'h00002013);
    chk("v1_vec0", 32'(vec1), 32'd0);
    @(posedge clk);
    #1;
    chk("v1_sum", 32'(sum1), 32'h0000CCF4);
    chk("v1_vec_pre", 32'(vec1), 32'd0);
    @(posedge clk);
    #1;
    chk("v1_vec1", 32'(vec1), 32'd1);
    chk("v1_err",  32'(err1), 32'd0);
    sbq.push_back(model_run(256, 0));
    finish_run1("lat1", 400);

    // carry bit dropped
    mode1 = 1;
    pulse1();
    drop_exp = model_run(256, 1);
    sbq.push_back(drop_exp);
    finish_run1("nocarry", 400);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", 32'(done1), 32'd1);
    chk("hold_err",  32'(err1),  32'(drop_exp.err));
    mode1 = 0;

    // start held through a whole run
    @(negedge clk);
    start1 = 1;
    @(posedge clk);
    #1;
    sbq.push_back(model_run(256, 0));
    finish_run1("held", 400);
    @(posedge clk);
    #1;
    chk("rerun_busy", 32'(busy1), 32'd1);
    chk("rerun_done", 32'(done1), 32'd0);
    chk("rerun_vec",  32'(vec1),  32'd0);
    chk("rerun_err",  32'(err1),  32'd0);
    start1 = 0;
    sbq.push_back(model_run(256, 0));
    finish_run1("held2", 400);
    repeat (4) @(posedge clk);
    #1;
    chk("one_run_done", 32'(done1), 32'd1);
    chk("one_run_busy", 32'(busy1), 32'd0);

    // reset in the middle of a run
    pulse1();
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    rst1 = 0;
    #1;
    chk("mr_a",    32'(a1),    32'd0);
    chk("mr_b",    32'(b1),    32'd0);
    chk("mr_busy", 32'(busy1), 32'd0);
    chk("mr_done", 32'(done1), 32'd0);
    chk("mr_pass", 32'(pass1), 32'd0);
    chk("mr_vec",  32'(vec1),  32'd0);
    chk("mr_err",  32'(err1),  32'd0);
    @(posedge clk);
    #1;
    chk("mr_busy_edge", 32'(busy1), 32'd0);
    @(negedge clk);
    rst1 = 1;
    repeat (2) @(posedge clk);
    pulse1();
    chk("rerun_a", 32'(a1), 32'h0000ACE1);
    chk("rerun_b", 32'(b1), 32'h00002013);
    sbq.push_back(model_run(256, 0));
    finish_run1("after_rst", 400);

    // wait for the long stuck-adder run
    cyc = 0;
    while (!done2 && cyc < 70000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("l8_done", 32'(done2), 32'd1);
    if (sb2.size() != 0) begin
      e = sb2.pop_front();
      chk("l8_vec",  32'(vec2),  32'(e.vec));
      chk("l8_err",  32'(err2),  32'(e.err));
      chk("l8_pass", 32'(pass2), 32'(e.pass));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adder_stim.md
ADDER_STIM -- requirements
Module: adder_stim

Interface
REQ-001 Parameter LATENCY, default 1, cycles from operands driven to sum valid at i_sum; legal 0..8.
REQ-002 Parameter NUM_VECTORS, default 256, operand pairs per run; legal 1..65535.
REQ-003 Parameter SEED, default 32'hACE1_2013, LFSR load value; nonzero.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_start  input  1  level, sampled in IDLE/DONE to begin a run.
REQ-007 o_a  output  16  operand A to adder under test.
REQ-008 o_b  output  16  operand B to adder under test.
REQ-009 i_sum  input  17  sum returned by adder under test.
REQ-010 o_busy  output  1  high in RUN or DRAIN.
REQ-011 o_done  output  1  high in DONE.
REQ-012 o_pass  output  1  high in DONE when o_err_count == 0.
REQ-013 o_err_count  output  16  mismatches this run, saturating.
REQ-014 o_vec_count  output  16  vectors checked this run.

Function
REQ-015 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-016 IDLE/DONE with i_start=1 -> RUN next cycle; clear both counters; reload LFSR with SEED.
REQ-017 RUN: each cycle issue one vector, o_a = lfsr[31:16], o_b = lfsr[15:0], then advance LFSR.
REQ-018 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, shifts only while issuing.
REQ-019 Expected value = {1'b0,o_a} + {1'b0,o_b}, 17-bit, no truncation.
REQ-020 Expected and valid flag delayed LATENCY cycles in a shift pipeline; LATENCY=0 compares same cycle.
REQ-021 Compare i_sum only when delayed valid=1; mismatch increments o_err_count, saturating at 16'hFFFF.
REQ-022 Each valid compare increments o_vec_count regardless of match.
REQ-023 After NUM_VECTORS issued -> DRAIN; o_a/o_b hold last vector; no new valids.
REQ-024 DRAIN -> DONE on the cycle after the last valid compare (o_vec_count == NUM_VECTORS).
REQ-025 DONE holds counters and o_pass until next i_start.
REQ-026 i_start ignored in RUN/DRAIN.
REQ-027 Outside RUN, o_a/o_b hold last issued value (zero after reset).

Reset
REQ-028 rst_n low: state IDLE, o_a=o_b=0, counters 0, pipeline valids 0, LFSR=SEED, o_busy=o_done=o_pass=0.
REQ-029 Reset mid-run abandons run immediately; no partial result reported.
REQ-030 Reset release synchronised internally; first i_start honoured no earlier than second clk edge after release.

Structure
REQ-031 Package adder_stim_pkg holds state enum, OPW=16, SUMW=17, CNTW=16, LFSR polynomial constant.
REQ-032 One sub-module adder_stim_lfsr (32-bit Galois LFSR, load, enable).
REQ-033 Top holds FSM, expected pipeline, comparator, counters.

Verification
REQ-034 Loopback correct combinational adder, LATENCY=0, NUM_VECTORS=4, i_start pulse -> o_done after 5 cycles, o_vec_count=4, o_err_count=0, o_pass=1.
REQ-035 Registered adder, LATENCY=1, first vector A=16'hACE1, B=16'h2013 -> expected 17'h0CCF4 checked one cycle later, pass.
REQ-036 Adder forced to drop carry bit 16, NUM_VECTORS=256 -> o_err_count equals count of vectors with A+B >= 17'h10000, o_pass=0.
REQ-037 rst_n low in RUN after 10 vectors -> all outputs reset values next edge; new i_start rerun yields identical first vector A=16'hACE1.
REQ-038 i_start held high through whole run -> exactly one run; DONE immediately re-enters RUN, counters cleared.
REQ-039 Adder stuck at 17'h1FFFF, NUM_VECTORS=65535, LATENCY=8 -> o_err_count=16'hFFFF saturated, o_vec_count=65535.
